// File: rtl/dma_copy_engine.sv
// dma_copy_engine: bus-mastering word copy engine on the DMA port.
// Reads one 16-bit word from the source, writes it to the destination,
// and repeats until the requested count is done, a bus error occurs or
// software aborts.
// Optional region guard: define DMA_COPY_ENGINE_GUARD_EN to refuse any
// access to the secure-data or counter regions.
module dma_copy_engine #(
  parameter logic [15:0] SDATA_BASE = 16'h0400,
  parameter logic [15:0] SDATA_SIZE = 16'h0C00,
  parameter logic [15:0] CTR_BASE   = 16'h9000,
  parameter logic [15:0] CTR_SIZE   = 16'h0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic [15:0] dma_dout,
  input  logic [15:0] dma_din,
  input  logic        dma_ready,
  input  logic        dma_resp
);

`ifdef DMA_COPY_ENGINE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  // Address LSBs are ignored: every access is a full word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = src_addr[0] ^ dst_addr[0];

  // True when an address falls inside a protected region (guard builds only).
  // 17-bit compare so a region ending at the top of memory cannot overflow.
  function automatic logic guard_hit(input logic [15:0] a);
    logic [16:0] a17;
    logic        in_sdata;
    logic        in_ctr;
    a17      = {1'b0, a};
    in_sdata = (a17 >= {1'b0, SDATA_BASE}) &&
               (a17 <  ({1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE}));
    in_ctr   = (a17 >= {1'b0, CTR_BASE}) &&
               (a17 <  ({1'b0, CTR_BASE} + {1'b0, CTR_SIZE}));
    return GUARD_EN && (in_sdata || in_ctr);
  endfunction

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      rem_q   <= 16'h0000;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: abort beats a completing access, a bus error ends the
  // copy, and each upcoming address is screened before it can be issued.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = {src_addr[15:1], 1'b0};
          dst_d = {dst_addr[15:1], 1'b0};
          rem_d = len;
          err_d = 1'b0;
          if (len == 16'h0000) begin
            state_d = DONE;
          end else if (guard_hit({src_addr[15:1], 1'b0})) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dma_ready) begin
          if (dma_resp) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d = dma_din;
            if (guard_hit(dst_q)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WR;
            end
          end
        end
      end
      WR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dma_ready) begin
          if (dma_resp) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            src_d = src_q + 16'd2;
            dst_d = dst_q + 16'd2;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = DONE;
            end else if (guard_hit(src_q + 16'd2)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decode straight from the registered state, so
  // address/enables/data stay stable through any number of wait cycles.
  always_comb begin
    busy     = (state_q == RD) || (state_q == WR);
    done     = (state_q == DONE);
    err      = err_q;
    dma_en   = (state_q == RD) || (state_q == WR);
    dma_we   = (state_q == WR) ? 2'b11 : 2'b00;
    dma_addr = 16'h0000;
    dma_dout = 16'h0000;
    if (state_q == RD) begin
      dma_addr = src_q;
    end else if (state_q == WR) begin
      dma_addr = dst_q;
      dma_dout = data_q;
    end
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Bus-mastering DMA engine that copies a block of 16-bit words from a source region to a destination region over the MCU's DMA port (dma_addr/dma_en/dma_we/dma_dout/dma_din/dma_ready). It is the initiator side of the DMA interface that the security monitors snoop. It sits between the software-visible start/configuration registers and the memory backbone's DMA slave port. It can optionally refuse transfers that would touch the protected secure-data or counter regions, so that a programming error cannot trigger a monitor-forced reset.

## Interface
- SDATA_BASE, 16'h0400, base of protected secure-data region (byte address)
- SDATA_SIZE, 16'h0C00, size of secure-data region in bytes
- CTR_BASE, 16'h9000, base of protected counter region
- CTR_SIZE, 16'h0020, size of counter region in bytes

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  **one clock; reset is synchronous and active-high**, sampled on posedge clk
- start  in  1  request a copy; accepted only in IDLE
- abort  in  1  cancel an in-progress copy
- src_addr  in  16  source byte address, word aligned (bit 0 ignored)
- dst_addr  in  16  destination byte address, word aligned (bit 0 ignored)
- len  in  16  number of words to copy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse, including error completion
- err  out  1  sticky error flag; cleared by reset or the next accepted start
- dma_addr  out  16  DMA byte address, bit 0 always 0
- dma_en  out  1  DMA access request
- dma_we  out  2  byte write enables: 2'b11 for a write, 2'b00 for a read
- dma_dout  out  16  write data
- dma_din  in  16  read data, valid when dma_ready=1
- dma_ready  in  1  slave accepts or completes the current access this cycle
- dma_resp  in  1  slave error, qualified by dma_ready

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 latches src/dst/len and clears err.
  - len=0 → DONE with no bus activity.
  - Otherwise → RD.
- RD:
  - Drives dma_en=1, dma_we=0, dma_addr=current src.
  - On dma_ready=1, captures dma_din into the data register and goes to WR.
- WR:
  - Drives dma_en=1, dma_we=2'b11, dma_addr=current dst, dma_dout=data register.
  - On dma_ready=1: src+=2, dst+=2, remaining-=1.
  - Remaining now 0 → DONE; otherwise → RD.
- DONE: done=1 and busy=0 for one cycle, then → IDLE.
- Handshake:
  - dma_addr, dma_we and dma_dout are held stable while dma_en=1 and dma_ready=0.
  - Wait states are unbounded.
- Bus error: dma_ready=1 with dma_resp=1 in RD or WR sets err and goes to DONE. The failed write is not counted.
- Address arithmetic:
  - Addresses are 16-bit, modulo 2^16, so 16'hFFFE+2 wraps to 16'h0000. Wrap is not an error.
  - The remaining count is 16-bit; len=16'hFFFF is legal.
- Abort:
  - abort=1 in RD or WR → IDLE on the next edge.
  - dma_en drops that edge; no done pulse; err unchanged.
  - abort has priority over dma_ready in the same cycle, so the access is treated as not completed by the engine.
- start while busy is ignored; inputs are not re-latched.
- reset has priority over everything; it may arrive mid-transfer.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, err=0, dma_en=0, dma_we=0, dma_addr=0, dma_dout=0.
  - All registers are cleared one edge after reset is sampled high.
- start sampled at edge 0 → dma_en=1 (read of src) from cycle 1.
- Zero-wait copy of N words:
  - Bus active in cycles 1..2N (read/write alternating).
  - done=1 in cycle 2N+1; busy=1 in cycles 1..2N.
- len=0: done=1 in cycle 1, busy stays 0.
- Each wait cycle (dma_ready=0) extends the corresponding access by exactly one cycle.
- Earliest next start acceptance is the DONE cycle+1 (IDLE).

## Configuration
- Macro: DMA_COPY_ENGINE_GUARD_EN.
- Defined:
  - Before entering RD or WR, the next address is checked combinationally against [SDATA_BASE, SDATA_BASE+SDATA_SIZE) and [CTR_BASE, CTR_BASE+CTR_SIZE).
  - On a hit, dma_en is never asserted for that address: err is set and the FSM goes to DONE.
  - A hit on the very first source address gives done in cycle 1 with no bus activity.
- Undefined: no region checks; all addresses are issued; the parameters are unused.

## Test plan
- Zero-wait copy: src=16'h0200, dst=16'h0300, len=3.
  - Expect read/write alternation in cycles 1..6 at 0200/0300, 0202/0302, 0204/0304.
  - Destination equals source data; done in cycle 7; err=0.
- Wait states: dma_ready low for 2 cycles on each access, len=1.
  - Expect addr/we/dout stable during the waits and done in cycle 7.
- Wrap and len=0:
  - src=16'hFFFE, len=2 → second read at 16'h0000 with no error.
  - Separately, len=0 → done in cycle 1 and no dma_en.
- Bus error: dma_resp=1 with dma_ready on the 2nd write of len=4.
  - Expect err=1, done the next cycle, and no further dma_en.
- Abort and reset mid-op:
  - abort during the 2nd read → dma_en=0 next cycle, no done.
  - reset during WR → all outputs 0 next cycle.
- Guard (macro defined): dst=16'h03FE, len=2.
  - Expect the first word copied, then no write to 16'h0400.
  - Expect err=1 and done; the same stimulus with the macro undefined writes 16'h0400.
